// File: rtl/mod_arith_pkg.sv
// ============================================================================
// mod_arith_pkg : shared types and defaults for the modular-exponentiation slice
// Revision 1.0
// ============================================================================
`default_nettype none

package mod_arith_pkg;

  localparam int unsigned MOD_EXP_K_DEFAULT = 8;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CHK      = 3'd1,
    S_CONV_B   = 3'd2,
    S_CONV_1   = 3'd3,
    S_SQR      = 3'd4,
    S_MUL      = 3'd5,
    S_CONV_OUT = 3'd6,
    S_FIN      = 3'd7
  } state_e;

  // States that own one Montgomery multiplication each
  function automatic logic is_mm_state(input state_e s);
    return (s == S_CONV_B) || (s == S_CONV_1) || (s == S_SQR) ||
           (s == S_MUL) || (s == S_CONV_OUT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mod_exp_ctrl.sv
// ============================================================================
// mod_exp_ctrl : left-to-right square-and-multiply sequencer driving an
//                external Montgomery multiplier
// Revision 1.0
// ============================================================================
`default_nettype none

module mod_exp_ctrl
  import mod_arith_pkg::*;
#(
  parameter int unsigned K = MOD_EXP_K_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [K-1:0] base,
  input  logic [K-1:0] expo,
  input  logic [K-1:0] m,
  input  logic [K-1:0] r2_mod_m,
  output logic [K-1:0] result,
  output logic         done,
  output logic         busy,
  output logic         err,
  output logic         mm_start,
  output logic [K-1:0] mm_a,
  output logic [K-1:0] mm_b,
  output logic [K-1:0] mm_m,
  input  logic         mm_done,
  input  logic [K-1:0] mm_p
);

  localparam int unsigned CW      = (K > 1) ? $clog2(K) : 1;
  localparam logic [K-1:0] C_ONE   = K'(1);
  localparam logic [K-1:0] C_THREE = K'(3);
  localparam logic [CW-1:0] C_TOP  = CW'(K - 1);

  state_e        state_q, state_d;
  logic [K-1:0]  base_q, expo_q, m_q, r2_q;
  logic [K-1:0]  x_q, bm_q, result_q;
  logic          err_q;
  logic [CW-1:0] cnt_q;
  logic          first_q;
  logic          pend_q;
  logic          mm_ack;
  logic          m_bad;

  // Completions are honoured only while an operation is actually outstanding
  assign mm_ack = pend_q & mm_done;
  assign m_bad  = ~m_q[0] | (m_q < C_THREE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start) state_d = S_CHK;
      S_CHK:      state_d = m_bad ? S_FIN : S_CONV_B;
      S_CONV_B:   if (mm_ack) state_d = S_CONV_1;
      S_CONV_1:   if (mm_ack) state_d = S_SQR;
      S_SQR: begin
        if (mm_ack) begin
          if (expo_q[cnt_q])          state_d = S_MUL;
          else if (cnt_q == '0)       state_d = S_CONV_OUT;
          else                        state_d = S_SQR;
        end
      end
      S_MUL:      if (mm_ack) state_d = (cnt_q == '0) ? S_CONV_OUT : S_SQR;
      S_CONV_OUT: if (mm_ack) state_d = S_FIN;
      S_FIN:      state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mm_start = first_q;
    busy     = (state_q != S_IDLE) && (state_q != S_FIN);
    done     = (state_q == S_FIN);
    mm_a     = '0;
    mm_b     = '0;
    case (state_q)
      S_CONV_B:   begin mm_a = base_q; mm_b = r2_q;  end
      S_CONV_1:   begin mm_a = C_ONE;  mm_b = r2_q;  end
      S_SQR:      begin mm_a = x_q;    mm_b = x_q;   end
      S_MUL:      begin mm_a = x_q;    mm_b = bm_q;  end
      S_CONV_OUT: begin mm_a = x_q;    mm_b = C_ONE; end
      default:    begin mm_a = '0;     mm_b = '0;    end
    endcase
  end

  assign mm_m   = m_q;
  assign result = result_q;
  assign err    = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q   <= '0;
      expo_q   <= '0;
      m_q      <= '0;
      r2_q     <= '0;
      x_q      <= '0;
      bm_q     <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      first_q  <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      // SQR->SQR re-entry is a new operation, so a completion also re-arms
      first_q <= is_mm_state(state_d) && ((state_d != state_q) || mm_ack);

      if (first_q)     pend_q <= 1'b1;
      else if (mm_ack) pend_q <= 1'b0;

      if (state_q == S_IDLE && start) begin
        base_q   <= base;
        expo_q   <= expo;
        m_q      <= m;
        r2_q     <= r2_mod_m;
        err_q    <= 1'b0;
        result_q <= '0;
      end

      if (state_q == S_CHK && m_bad) begin
        err_q    <= 1'b1;
        result_q <= '0;
      end

      if (mm_ack) begin
        case (state_q)
          S_CONV_B: bm_q <= mm_p;
          S_CONV_1: begin
            x_q   <= mm_p;
            cnt_q <= C_TOP;
          end
          S_SQR: begin
            x_q <= mm_p;
            if (!expo_q[cnt_q] && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
          end
          S_MUL: begin
            x_q <= mm_p;
            if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
          end
          S_CONV_OUT: result_q <= mm_p;
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mod_exp_ctrl.sv
// ============================================================================
// tb_mod_exp_ctrl : randomized self-checking bench with a Montgomery multiplier model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_mod_exp_ctrl;

  localparam int K = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [K-1:0] base, expo, m, r2_mod_m;
  logic [K-1:0] result;
  logic         done, busy, err;
  logic         mm_start;
  logic [K-1:0] mm_a, mm_b, mm_m;
  logic         mm_done;
  logic [K-1:0] mm_p;

  int n_cmp = 0;
  int n_bad = 0;
  int n_start = 0;

  mod_exp_ctrl #(.K(K)) dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .expo(expo), .m(m),
    .r2_mod_m(r2_mod_m), .result(result), .done(done), .busy(busy), .err(err),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
    .mm_done(mm_done), .mm_p(mm_p)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // a*b*2^-K mod m, found as the residue p with p*2^K == a*b (mod m)
  function automatic int mont(input int a, input int b, input int mod);
    int t;
    if (mod == 0) return 0;
    t = (a * b) % mod;
    for (int p = 0; p < mod; p++)
      if (((p << K) % mod) == t) return p;
    return 0;
  endfunction

  function automatic int ref_pow(input int b, input int e, input int mod);
    int r;
    r = 1 % mod;
    for (int i = 0; i < e; i++) r = (r * b) % mod;
    return r;
  endfunction

  // mmm_model: behavioural Montgomery multiplier with random latency
  logic [K-1:0] mdl_a, mdl_b, mdl_p;
  bit           mdl_pend = 0;
  bit           mdl_stale = 0;
  int           mdl_cnt = 0;

  always @(negedge clk) begin
    mm_done = 1'b0;
    if (mdl_pend) begin
      if (rst) mdl_stale = 1;
      if (!rst && !mdl_stale) begin
        chk("mm_a_stable", mm_a, mdl_a);
        chk("mm_b_stable", mm_b, mdl_b);
        chk("one_outstanding", mm_start, 0);
      end
      if (mdl_cnt == 0) begin
        mm_done   = 1'b1;
        mm_p      = mdl_p;
        mdl_pend  = 0;
        mdl_stale = 0;
      end else begin
        mdl_cnt--;
      end
    end else if (mm_start) begin
      n_start++;
      mdl_a    = mm_a;
      mdl_b    = mm_b;
      mdl_p    = K'(mont(int'(mm_a), int'(mm_b), int'(mm_m)));
      mdl_cnt  = $urandom_range(0, 3);
      mdl_pend = 1;
    end else if ($urandom_range(0, 7) == 0) begin
      mm_done = 1'b1;
      mm_p    = K'($urandom);
    end
  end

  task automatic launch(input logic [K-1:0] b, input logic [K-1:0] e, input logic [K-1:0] mm);
    @(negedge clk);
    base     = b;
    expo     = e;
    m        = mm;
    r2_mod_m = (mm != 0) ? K'((1 << (2 * K)) % int'(mm)) : '0;
    start    = 1'b1;
    n_start  = 0;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic run_op(input logic [K-1:0] b, input logic [K-1:0] e,
                        input logic [K-1:0] mm, input bit poke);
    int cyc;
    bit valid;
    int exp_res;
    valid = mm[0] && (mm >= 3);
    exp_res = valid ? ref_pow(int'(b), int'(e), int'(mm)) : 0;
    launch(b, e, mm);
    cyc = 1;
    if (poke) begin
      repeat (4) @(negedge clk);
      base  = ~b;
      expo  = ~e;
      m     = 8'd11;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc += 5;
    end
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) begin
      chk("done_timeout", 0, 1);
    end else begin
      chk("result", result, exp_res);
      chk("err", err, valid ? 0 : 1);
      chk("mm_start_count", n_start, valid ? (K + $countones(e) + 3) : 0);
      if (!valid) chk("err_latency", cyc, 2);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("result_held", result, exp_res);
    end
  endtask

  initial begin
    logic [K-1:0] rm, rb, re;
    int wt;
    rst = 1'b1; start = 1'b0; base = '0; expo = '0; m = '0; r2_mod_m = '0;
    mm_done = 1'b0; mm_p = '0;
    repeat (3) @(negedge clk);
    chk("rst_result", result, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_mm_start", mm_start, 0);
    chk("rst_mm_a", mm_a, 0);
    chk("rst_mm_b", mm_b, 0);
    chk("rst_mm_m", mm_m, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_op(8'd3,  8'd5, 8'd13,  0);
    run_op(8'd7,  8'd0, 8'd13,  0);
    run_op(8'd12, 8'd2, 8'd13,  0);
    run_op(8'd2,  8'd8, 8'd255, 0);
    run_op(8'd5,  8'd3, 8'd12,  0);
    run_op(8'd1,  8'd9, 8'd1,   0);

    // Reset in the middle of the squaring phase, then a clean run
    launch(8'd3, 8'd5, 8'd13);
    wt = 0;
    while (n_start < 4 && wt < 200) begin
      @(negedge clk);
      wt++;
    end
    chk("reached_sqr", (n_start >= 4) ? 1 : 0, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_result", result, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("post_rst_done", done, 0);
    run_op(8'd3, 8'd5, 8'd13, 0);

    run_op(8'd3, 8'd5, 8'd13, 1);

    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 4) == 0) rm = K'($urandom);
      else rm = K'($urandom_range(1, 127) * 2 + 1);
      rb = (rm != 0) ? K'($urandom % rm) : K'($urandom);
      re = K'($urandom);
      run_op(rb, re, rm, (rm[0] && rm >= 3) ? bit'($urandom_range(0, 1)) : 1'b0);
    end

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
